// File: rtl/prg_saver_pkg.sv
// Shared types and constants for the PET .PRG save path.
// The START/TOP defaults are the same ones the PRG loader uses.
package pet_save_pkg;

   typedef enum logic [3:0] {
      IDLE,
      PTR_LO,
      PTR_HI,
      CALC,
      HDR_LO,
      HDR_HI,
      RD,
      SEND,
      DONE
   } save_state_e;

   // BASIC keeps the end-of-program pointer (VARTAB) in zero page here
   localparam logic [15:0] VARTAB_LO      = 16'h002A;
   localparam logic [15:0] VARTAB_HI      = 16'h002B;
   localparam logic [15:0] START_ADDR_DEF = 16'h0401;
   localparam logic [15:0] RAM_TOP_DEF    = 16'h8000;

   function automatic logic [15:0] clamp_end(input logic [15:0] end_ptr,
                                             input logic [15:0] top);
      return (end_ptr > top) ? top : end_ptr;
   endfunction

endpackage

// File: rtl/prg_saver_if.sv
// DMA read port and HPS upload stream used by the PRG saver.
interface prg_saver_if;

   logic [15:0] dma_addr;
   logic        dma_rd;
   logic [7:0]  dma_din;

   // Upload handshake: a byte moves in every cycle with upl_valid && upl_ready.
   // While upl_valid && !upl_ready, upl_valid/upl_dout/upl_addr hold steady;
   // upl_ready may change freely and does not depend on upl_valid.
   logic [24:0] upl_addr;
   logic [7:0]  upl_dout;
   logic        upl_valid;
   logic        upl_ready;

   modport master (
      output dma_addr, dma_rd, upl_addr, upl_dout, upl_valid,
      input  dma_din, upl_ready
   );

   modport slave (
      input  dma_addr, dma_rd, upl_addr, upl_dout, upl_valid,
      output dma_din, upl_ready
   );

endinterface

// File: rtl/prg_saver_dma_rd_pipe.sv
// One-shot RAM read: registers a single-cycle strobe, counts the read latency
// and flags the cycle in which dma_din carries the requested byte.
module dma_rd_pipe #(
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req,
   input  logic [15:0] req_addr,
   input  logic        flush,
   output logic        dma_rd,
   output logic [15:0] dma_addr,
   input  logic [7:0]  dma_din,
   output logic        rd_done,
   output logic [7:0]  rd_data
);

   localparam logic [1:0] LAT = 2'(RD_LAT);

   logic [1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dma_rd   <= 1'b0;
         dma_addr <= 16'h0000;
         cnt      <= 2'd0;
      end else begin
         dma_rd <= req && !flush;
         // address stays put until the next request, covering the whole latency
         if (req && !flush) dma_addr <= req_addr;
         if (flush)               cnt <= 2'd0;
         else if (dma_rd)         cnt <= LAT;
         else if (cnt != 2'd0)    cnt <= cnt - 2'd1;
      end
   end

   assign rd_done = (cnt == 2'd1);
   assign rd_data = dma_din;

endmodule

// File: rtl/prg_saver.sv
// Streams the BASIC program in PET RAM to the HPS as a .PRG image:
// two-byte load address header followed by START_ADDR .. VARTAB-1.
module prg_saver
   import pet_save_pkg::*;
#(
   parameter logic [15:0] START_ADDR = START_ADDR_DEF,
   parameter logic [15:0] RAM_TOP    = RAM_TOP_DEF,
   parameter int          RD_LAT     = 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic          empty,
   output logic [15:0]   upl_size,
   output save_state_e   state_dbg,
   prg_saver_if.master   bus
);

   save_state_e state, nxt;

   logic        req, flush, rd_done;
   logic [15:0] req_addr;
   logic [7:0]  rd_data;
   logic [7:0]  end_lo;
   logic [15:0] end_ptr, endc, ptr;
   logic        len_zero;
   logic [24:0] upl_addr_q;
   logic [7:0]  upl_dout_q;
   logic        upl_valid_c, hs, last_byte;
   logic [15:0] endc_c, len_c;

   dma_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
      .clk      (clk),
      .reset_n  (reset_n),
      .req      (req),
      .req_addr (req_addr),
      .flush    (flush),
      .dma_rd   (bus.dma_rd),
      .dma_addr (bus.dma_addr),
      .dma_din  (bus.dma_din),
      .rd_done  (rd_done),
      .rd_data  (rd_data)
   );

   // endc <= RAM_TOP keeps len + 2 within 16 bits and ptr from wrapping
   assign endc_c    = clamp_end(end_ptr, RAM_TOP);
   assign len_c     = (endc_c > START_ADDR) ? (endc_c - START_ADDR) : 16'h0000;
   assign hs        = upl_valid_c && bus.upl_ready;
   assign last_byte = ((ptr + 16'd1) == endc);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (start && !abort) nxt = PTR_LO;
         PTR_LO:  if (rd_done) nxt = PTR_HI;
         PTR_HI:  if (rd_done) nxt = CALC;
         CALC:    nxt = HDR_LO;
         HDR_LO:  if (hs) nxt = HDR_HI;
         HDR_HI:  if (hs) nxt = len_zero ? DONE : RD;
         RD:      if (rd_done) nxt = SEND;
         SEND:    if (hs) nxt = last_byte ? DONE : RD;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
      if (abort && (state != IDLE) && (state != DONE)) nxt = DONE;
   end

   always_comb begin
      busy        = (state != IDLE) && (state != DONE);
      done        = (state == DONE);
      upl_valid_c = (state == HDR_LO) || (state == HDR_HI) || (state == SEND);
      flush       = abort && (state != IDLE);
      // a read is launched on entry to a read state, so the strobe is one cycle
      req         = (nxt != state) &&
                    ((nxt == PTR_LO) || (nxt == PTR_HI) || (nxt == RD));
      case (nxt)
         PTR_LO:  req_addr = VARTAB_LO;
         PTR_HI:  req_addr = VARTAB_HI;
         default: req_addr = (state == SEND) ? (ptr + 16'd1) : ptr;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         end_lo     <= 8'h00;
         end_ptr    <= 16'h0000;
         endc       <= 16'h0000;
         len_zero   <= 1'b0;
         ptr        <= 16'h0000;
         upl_addr_q <= 25'd0;
         upl_dout_q <= 8'h00;
         upl_size   <= 16'h0000;
         empty      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start && !abort) begin
               empty      <= 1'b0;
               upl_addr_q <= 25'd0;
               upl_size   <= 16'h0000;
            end
            PTR_LO: if (rd_done) end_lo <= rd_data;
            PTR_HI: if (rd_done) end_ptr <= {rd_data, end_lo};
            CALC: begin
               endc       <= endc_c;
               len_zero   <= (len_c == 16'h0000);
               empty      <= (len_c == 16'h0000);
               upl_size   <= len_c + 16'd2;
               ptr        <= START_ADDR;
               upl_dout_q <= START_ADDR[7:0];
            end
            HDR_LO: if (hs) begin
               upl_addr_q <= upl_addr_q + 25'd1;
               upl_dout_q <= START_ADDR[15:8];
            end
            HDR_HI: if (hs) upl_addr_q <= upl_addr_q + 25'd1;
            RD:     if (rd_done) upl_dout_q <= rd_data;
            SEND: if (hs) begin
               upl_addr_q <= upl_addr_q + 25'd1;
               ptr        <= ptr + 16'd1;
            end
            default: ;
         endcase
      end
   end

   assign bus.upl_valid = upl_valid_c;
   assign bus.upl_addr  = upl_addr_q;
   assign bus.upl_dout  = upl_dout_q;
   assign state_dbg     = state;

endmodule
